dm_responder: RTL and testbench

Multi-cycle data-memory responder that services the pipeline's MEM-stage load/store requests over a req/ack handshake. It inserts a programmable number of wait states, so the core's MEM stage can stall on a slow memory. It performs byte-lane writes (sw/sh/sb) and sign/zero-extended reads (lw/lh/lhu/lb/lbu). It flags misaligned, out-of-range and malformed accesses.

---
 rtl/dm_responder.sv | 184 ++++++++++++++++++
 tb/tb_dm_responder.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/dm_responder.sv
// dm_responder: multi-cycle data-memory responder for the MEM stage.
// Accepts one load/store per req in IDLE, waits LATENCY cycles, then
// commits the store / registers the load result and pulses ack for one cycle.
module dm_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [1:0]  DMWr,
    input  logic [3:0]  DMRd,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy
);

    localparam int          IDXW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [29:0] DEPTH30 = 30'(DEPTH_WORDS);
    localparam logic [3:0]  LAT     = 4'(LATENCY);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;

    // captured request
    logic [1:0]  wr_q;
    logic [3:0]  rd_q;
    logic [31:0] addr_q, wdata_q;

    // request seen by the decode: live inputs while IDLE (needed when
    // LATENCY=0 enters RESP on the accept edge), captured copy otherwise
    logic [1:0]  cur_wr;
    logic [3:0]  cur_rd;
    logic [31:0] cur_addr, cur_wdata;

    logic        enter_resp;
    logic        err_n, we_n;
    logic [31:0] rdata_n, wd_n, word, rd_val;
    logic [3:0]  be_n;
    logic [15:0] half;
    logic [7:0]  byte_v;
    logic [IDXW-1:0] idx;

    logic [31:0] mem [DEPTH_WORDS];

    // state register and wait counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // next-state logic
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (req) begin
                    cnt_n   = LAT;
                    state_n = (LAT == 4'd0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt <= 4'd1) state_n = RESP;
                cnt_n = cnt - 4'd1;
            end
            RESP: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign enter_resp = (state_n == RESP) && (state != RESP);

    // capture the request on accept; later input changes are ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state == IDLE && req) begin
            wr_q    <= DMWr;
            rd_q    <= DMRd;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    // select live vs captured request
    always_comb begin
        cur_wr    = (state == IDLE) ? DMWr  : wr_q;
        cur_rd    = (state == IDLE) ? DMRd  : rd_q;
        cur_addr  = (state == IDLE) ? addr  : addr_q;
        cur_wdata = (state == IDLE) ? wdata : wdata_q;
    end

    assign idx = cur_addr[IDXW+1:2];

    // decode: error detection, byte enables and load extraction
    always_comb begin
        logic noop, oob, bad_rd, both, mis_w, mis_h;
        noop   = (cur_wr == 2'b00) && (cur_rd == 4'd0);
        oob    = cur_addr[31:2] >= DEPTH30;
        bad_rd = cur_rd > 4'd5;
        both   = (cur_wr != 2'b00) && (cur_rd != 4'd0);
        mis_w  = ((cur_wr == 2'b01) || (cur_rd == 4'd1)) && (cur_addr[1:0] != 2'b00);
        mis_h  = ((cur_wr == 2'b10) || (cur_rd == 4'd2) || (cur_rd == 4'd3)) && cur_addr[0];
        err_n  = !noop && (oob || bad_rd || both || mis_w || mis_h);
        we_n   = (cur_wr != 2'b00) && !err_n;

        be_n = 4'b0000;
        wd_n = '0;
        unique case (cur_wr)
            2'b01: begin
                be_n = 4'b1111;
                wd_n = cur_wdata;
            end
            2'b10: begin
                be_n = cur_addr[1] ? 4'b1100 : 4'b0011;
                wd_n = {2{cur_wdata[15:0]}};
            end
            2'b11: begin
                be_n = 4'b0001 << cur_addr[1:0];
                wd_n = {4{cur_wdata[7:0]}};
            end
            default: ;
        endcase

        word = mem[idx];
        half = cur_addr[1] ? word[31:16] : word[15:0];
        unique case (cur_addr[1:0])
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            default: byte_v = word[31:24];
        endcase

        unique case (cur_rd)
            4'd1:    rd_val = word;
            4'd2:    rd_val = {{16{half[15]}}, half};
            4'd3:    rd_val = {16'h0, half};
            4'd4:    rd_val = {{24{byte_v[7]}}, byte_v};
            4'd5:    rd_val = {24'h0, byte_v};
            default: rd_val = '0;
        endcase
        rdata_n = err_n ? 32'h0 : rd_val;
    end

    // memory write: commits only on the RESP-entry edge, never during reset
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && we_n) begin
            for (int k = 0; k < 4; k++)
                if (be_n[k]) mem[idx][8*k +: 8] <= wd_n[8*k +: 8];
        end
    end

    // response registers: loaded entering RESP, cleared when leaving it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
            err   <= 1'b0;
        end else if (enter_resp) begin
            rdata <= rdata_n;
            err   <= err_n;
        end else if (state == RESP) begin
            rdata <= '0;
            err   <= 1'b0;
        end
    end

    assign ack  = (state == RESP);
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: one LATENCY=2 instance, one LATENCY=0
// instance sharing the request fields; expected responses via a scoreboard.
module tb_dm_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  DMWr;
    logic [3:0]  DMRd;
    logic [31:0] addr, wdata;
    logic        req, ack, err, busy;
    logic [31:0] rdata;
    logic        req0, ack0, err0, busy0;
    logic [31:0] rdata0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t sb[$];
    int    vecs  = 0;
    int    fails = 0;

    always #5 clk = ~clk;

    dm_responder #(.DEPTH_WORDS(64), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .req(req), .DMWr(DMWr), .DMRd(DMRd),
        .addr(addr), .wdata(wdata), .ack(ack), .rdata(rdata), .err(err), .busy(busy)
    );

    dm_responder #(.DEPTH_WORDS(64), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .req(req0), .DMWr(DMWr), .DMRd(DMRd),
        .addr(addr), .wdata(wdata), .ack(ack0), .rdata(rdata0), .err(err0), .busy(busy0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // one transaction on the selected instance (z=1 -> LATENCY=0 instance)
    task automatic txn(input bit z, input logic [1:0] w, input logic [3:0] r,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] er, input logic ee, input string tag);
        int    lat, n;
        bit    got;
        resp_t e;
        lat = z ? 0 : 2;
        sb.push_back('{rdata: er, err: ee});
        @(negedge clk);
        DMWr = w; DMRd = r; addr = a; wdata = d;
        if (z) req0 = 1'b1; else req = 1'b1;
        n = 0; got = 0;
        while (!got && n < 20) begin
            @(posedge clk); n++; #1;
            if (n == 1) begin
                // scramble inputs after accept; the captured copy must be used
                req = 1'b0; req0 = 1'b0;
                DMWr = 2'b11; DMRd = 4'd1; addr = 32'h4; wdata = 32'hFFFF_FFFF;
                if (!z) check({tag, " busy"}, {31'b0, busy}, 32'd1);
            end
            got = z ? ack0 : ack;
        end
        check({tag, " latency"}, n, lat + 1);
        e = sb.pop_front();
        check({tag, " rdata"}, z ? rdata0 : rdata, e.rdata);
        check({tag, " err"}, {31'b0, z ? err0 : err}, {31'b0, e.err});
        @(posedge clk); #1;
        check({tag, " ack drop"}, {31'b0, z ? ack0 : ack}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; req0 = 1'b0;
        DMWr = 2'b00; DMRd = 4'd0; addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst ack",   {31'b0, ack},  32'd0);
        check("rst busy",  {31'b0, busy}, 32'd0);
        check("rst err",   {31'b0, err},  32'd0);
        check("rst rdata", rdata,         32'd0);
        check("rst busy0", {31'b0, busy0}, 32'd0);
        @(negedge clk); rst = 1'b0;

        // basic word store/load
        txn(0, 2'b01, 4'd0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, "sw10");
        txn(0, 2'b00, 4'd1, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, "lw10");

        // byte / half lanes
        txn(0, 2'b01, 4'd0, 32'h20, 32'h11223344, 32'h0,        1'b0, "sw20");
        txn(0, 2'b11, 4'd0, 32'h21, 32'h000000AA, 32'h0,        1'b0, "sb21");
        txn(0, 2'b10, 4'd0, 32'h22, 32'h0000BEEF, 32'h0,        1'b0, "sh22");
        txn(0, 2'b00, 4'd1, 32'h20, 32'h0,        32'hBEEFAA44, 1'b0, "lw20");
        txn(0, 2'b00, 4'd4, 32'h21, 32'h0,        32'hFFFFFFAA, 1'b0, "lb21");
        txn(0, 2'b00, 4'd5, 32'h21, 32'h0,        32'h000000AA, 1'b0, "lbu21");
        txn(0, 2'b00, 4'd2, 32'h22, 32'h0,        32'hFFFFBEEF, 1'b0, "lh22");
        txn(0, 2'b00, 4'd3, 32'h22, 32'h0,        32'h0000BEEF, 1'b0, "lhu22");
        txn(0, 2'b00, 4'd3, 32'h20, 32'h0,        32'h0000AA44, 1'b0, "lhu20");
        txn(0, 2'b00, 4'd4, 32'h23, 32'h0,        32'hFFFFFFBE, 1'b0, "lb23");
        txn(0, 2'b00, 4'd5, 32'h20, 32'h0,        32'h00000044, 1'b0, "lbu20");

        // error cases
        txn(0, 2'b00, 4'd1, 32'h22, 32'h0,        32'h0,        1'b1, "lw22 mis");
        txn(0, 2'b10, 4'd0, 32'h23, 32'h0000CCCC, 32'h0,        1'b1, "sh23 mis");
        txn(0, 2'b00, 4'd1, 32'h20, 32'h0,        32'hBEEFAA44, 1'b0, "lw20 after sh23");
        txn(0, 2'b00, 4'd1, 32'h100, 32'h0,       32'h0,        1'b1, "lw oob");
        txn(0, 2'b01, 4'd1, 32'h20, 32'h12345678, 32'h0,        1'b1, "sw+lw");
        txn(0, 2'b00, 4'd1, 32'h20, 32'h0,        32'hBEEFAA44, 1'b0, "lw20 after sw+lw");
        txn(0, 2'b00, 4'd7, 32'h20, 32'h0,        32'h0,        1'b1, "rd illegal");
        txn(0, 2'b00, 4'd2, 32'h21, 32'h0,        32'h0,        1'b1, "lh21 mis");
        txn(0, 2'b00, 4'd0, 32'h24, 32'h0,        32'h0,        1'b0, "noop");

        // LATENCY=0 instance
        txn(1, 2'b01, 4'd0, 32'h8, 32'hCAFEF00D,  32'h0,        1'b0, "z sw8");
        txn(1, 2'b00, 4'd1, 32'h8, 32'h0,         32'hCAFEF00D, 1'b0, "z lw8");
        txn(1, 2'b00, 4'd2, 32'h8, 32'h0,         32'hFFFFF00D, 1'b0, "z lh8");

        // LATENCY=0, req held high: ack/busy alternate, never double-accepted
        @(negedge clk);
        DMWr = 2'b00; DMRd = 4'd1; addr = 32'h8; req0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check($sformatf("hold ack%0d", i),  {31'b0, ack0},  (i % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("hold busy%0d", i), {31'b0, busy0}, (i % 2 == 0) ? 32'd1 : 32'd0);
            if (i % 2 == 0) check($sformatf("hold rdata%0d", i), rdata0, 32'hCAFEF00D);
        end
        req0 = 1'b0;

        // reset in WAIT aborts the store
        txn(0, 2'b01, 4'd0, 32'h30, 32'h1, 32'h0, 1'b0, "sw30=1");
        @(negedge clk);
        DMWr = 2'b01; DMRd = 4'd0; addr = 32'h30; wdata = 32'h5; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        check("abort busy pre", {31'b0, busy}, 32'd1);
        rst = 1'b1; #1;
        check("abort busy", {31'b0, busy}, 32'd0);
        check("abort ack",  {31'b0, ack},  32'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("abort ack rst", {31'b0, ack}, 32'd0);
        end
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("abort no ack", {31'b0, ack}, 32'd0);
        end
        txn(0, 2'b00, 4'd1, 32'h30, 32'h0, 32'h1, 1'b0, "lw30");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
